affine_addr_gen: RTL
====================

// Module: affine_addr_gen
// PURPOSE
//  Parametrised N-dimensional affine address generator. It is the successor to the fixed
//  2-level scan-counter chains. It walks a loop nest of NUM_DIMS counters, dim 0 innermost,
//  and emits addr = offset + sum(idx[d]*stride[d]) once per accepted beat.
//  It sits between the config registers and a memory port, with a valid/ready output
//  handshake and start/done sequencing.
// PARAMETERS
//  NUM_DIMS  3   number of nested loop dimensions (1..8)
//  WIDTH     16  width of extents, strides, offset, indices and address
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst        in   1                 asynchronous active-high reset
//  start      in   1                 begin a new walk (accepted only in IDLE)
//  cfg_extent in   NUM_DIMS*WIDTH    packed extents, dim d at [d*WIDTH +: WIDTH]
//  cfg_stride in   NUM_DIMS*WIDTH    packed strides, same packing, two's complement
//  cfg_offset in   WIDTH             base address
//  addr_valid out  1                 addr_out holds a valid address
//  addr_ready in   1                 consumer accepts the address this cycle
//  addr_out   out  WIDTH             current address
//  addr_last  out  1                 current beat is the final beat of the walk
//  busy       out  1                 high in RUN
//  done       out  1                 one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all idx and accumulators 0.
//   - addr_valid=0, addr_out=0, addr_last=0, busy=0, done=0.
//   - Reset asserted mid-walk aborts it immediately; done is not pulsed.
//  State machine: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 latches cfg_extent, cfg_stride and cfg_offset into shadow registers,
//         clears all idx, and moves to RUN next cycle. cfg_* are ignored outside this cycle.
//   RUN:  addr_valid=1, busy=1. A beat fires when addr_valid & addr_ready.
//   DONE: single cycle with done=1, addr_valid=0; returns to IDLE.
//   - start is ignored in RUN and DONE; no queuing.
//  Beat advance, on a fire in RUN:
//   - dim d increments iff every dim below it is at max (idx[k]==extent[k]-1 for k<d).
//   - A dim that is at max and whose lower dims are all at max wraps to 0.
//   - Last beat = all dims at max. On firing the last beat: state -> DONE; idx are not
//     advanced further.
//   - addr_last = (state==RUN) & all dims at max.
//  Address:
//   - addr_out = offset + sum(idx[d]*stride[d]), computed modulo 2^WIDTH (wrap, no
//     saturation).
//   - Registered and valid in the same cycle as addr_valid: the first address (=offset)
//     appears on the first RUN cycle.
//   - Implemented incrementally, with no multipliers. One accumulator per dim: add
//     stride[d] on increment, subtract (extent[d]-1)*stride[d] on wrap. That product is
//     precomputed at start over up to NUM_DIMS cycles, or by shift-add.
//   - If the implementation adds precompute cycles, RUN entry is delayed accordingly,
//     addr_valid stays 0 during them, and this is documented as START_LAT. The target is
//     START_LAT=1: the RUN entry cycle itself.
//  Stall: addr_valid=1 & addr_ready=0 holds addr_out, addr_last and all idx unchanged.
//   addr_valid never drops in RUN until the last beat fires.
//  Boundary rules:
//   - extent 0 is treated as 1.
//   - All extents 1: a single beat at addr=offset with addr_last=1.
//   - Negative strides are legal; arithmetic wraps.
//   - Total beats = product of extents. Overflow of that count is not tracked.
// TESTING
//  1 NUM_DIMS=2, extent={3,2}, stride={1,10}, offset=100, ready=1 -> addr 100,101,102,
//    110,111,112; addr_last on 112; done pulses 1 cycle after.
//  2 Same config with ready toggling 1,0 -> identical address sequence; address held
//    stable while ready=0; no beat lost or repeated.
//  3 extent={1,1,1}, offset=7 -> exactly one beat, addr 7, addr_last=1, then done, then
//    IDLE.
//  4 WIDTH=16, offset=16'hFFFE, stride0=1, extent0=4 -> FFFE, FFFF, 0000, 0001 (wrap).
//  5 stride0=-2 (16'hFFFE), extent0=3, offset=10 -> 10, 8, 6. extent1=0 treated as 1.
//  6 Assert rst mid-walk at beat 3 -> next cycle addr_valid=0, busy=0, done=0. A new
//    start replays from offset.

Source files
------------

// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: walks a loop nest (dim 0 innermost) and emits
// offset + sum(idx[d]*stride[d]) once per accepted beat, with valid/ready and start/done.
module affine_addr_gen #(
  parameter int NUM_DIMS = 3,
  parameter int WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_DIMS*WIDTH-1:0] cfg_extent,
  input  logic [NUM_DIMS*WIDTH-1:0] cfg_stride,
  input  logic [WIDTH-1:0]          cfg_offset,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic [WIDTH-1:0]          addr_out,
  output logic                      addr_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Shadow configuration: extents are stored as their maximum index (extent 0 -> 0).
  logic [WIDTH-1:0] max_reg    [NUM_DIMS];
  logic [WIDTH-1:0] stride_reg [NUM_DIMS];
  logic [WIDTH-1:0] idx_reg    [NUM_DIMS];
  // acc_reg[d] tracks idx[d]*stride[d]; when dim d wraps it equals (extent-1)*stride,
  // which is exactly the amount to subtract, so no precompute cycles are needed.
  logic [WIDTH-1:0] acc_reg    [NUM_DIMS];
  logic [WIDTH-1:0] delta      [NUM_DIMS];
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] delta_sum;

  logic [NUM_DIMS-1:0] at_max;
  logic [NUM_DIMS:0]   low_max;   // low_max[d]: every dim below d is at its max
  logic                last_beat;
  logic                load;
  logic                fire;
  logic                advance;

  assign low_max[0] = 1'b1;
  assign last_beat  = low_max[NUM_DIMS];
  assign advance    = fire & ~last_beat;

  generate
    for (genvar gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
      logic [WIDTH-1:0] ext_slice;
      assign ext_slice      = cfg_extent[gi*WIDTH +: WIDTH];
      assign at_max[gi]     = (idx_reg[gi] == max_reg[gi]);
      assign low_max[gi+1]  = low_max[gi] & at_max[gi];

      always_comb begin
        delta[gi] = '0;
        if (low_max[gi]) begin
          if (at_max[gi]) delta[gi] = '0 - acc_reg[gi];
          else            delta[gi] = stride_reg[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          max_reg[gi]    <= '0;
          stride_reg[gi] <= '0;
          idx_reg[gi]    <= '0;
          acc_reg[gi]    <= '0;
        end else if (load) begin
          max_reg[gi]    <= (ext_slice == '0) ? '0 : ext_slice - 1'b1;
          stride_reg[gi] <= cfg_stride[gi*WIDTH +: WIDTH];
          idx_reg[gi]    <= '0;
          acc_reg[gi]    <= '0;
        end else if (advance && low_max[gi]) begin
          if (at_max[gi]) begin
            idx_reg[gi] <= '0;
            acc_reg[gi] <= '0;
          end else begin
            idx_reg[gi] <= idx_reg[gi] + 1'b1;
            acc_reg[gi] <= acc_reg[gi] + stride_reg[gi];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    delta_sum = '0;
    for (int d = 0; d < NUM_DIMS; d++) delta_sum = delta_sum + delta[d];
  end

  // The running address starts at offset so the first beat is valid on RUN entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          addr_reg <= '0;
    else if (load)    addr_reg <= cfg_offset;
    else if (advance) addr_reg <= addr_reg + delta_sum;
  end

  assign addr_out = addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    fire       = 1'b0;
    addr_valid = 1'b0;
    addr_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        addr_last  = last_beat;
        fire       = addr_ready;
        if (addr_ready && last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
